// File: rtl/timer_bcd_up_counter_if.sv
// rtl/timer_bcd_up_counter_if.sv - control, target and display bundle for the MM:SS up counter
interface timer_bcd_up_counter_if;
    logic       start;
    logic       pause;
    logic       clear;
    logic [3:0] target_min_tens;
    logic [3:0] target_min_units;
    logic [3:0] target_sec_tens;
    logic [3:0] target_sec_units;
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic       running;
    logic       done;
    logic       overflow;

    modport master (
        output start, pause, clear,
        output target_min_tens, target_min_units, target_sec_tens, target_sec_units,
        input  min_tens, min_units, sec_tens, sec_units, running, done, overflow
    );

    modport slave (
        input  start, pause, clear,
        input  target_min_tens, target_min_units, target_sec_tens, target_sec_units,
        output min_tens, min_units, sec_tens, sec_units, running, done, overflow
    );
endinterface

// File: rtl/timer_bcd_up_counter.sv
// rtl/timer_bcd_up_counter.sv - BCD MM:SS elapsed-time counter with target stop
// Optional macro TIMER_UP_WRAP_EN: wrap 59:59 -> 00:00 instead of saturating.
module timer_bcd_up_counter #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PRESC_W       = 26
) (
    input  logic                        clk,
    input  logic                        reset,
    timer_bcd_up_counter_if.slave       bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t             state;
    logic [PRESC_W-1:0] presc;
    logic [3:0]         mt, mu, st, su;
    logic [15:0]        tgt;
    logic               running, done, overflow;

    logic [3:0] n_mt, n_mu, n_st, n_su;
    logic       c0, c1, c2, roll;
    logic       sec_tick, tgt_valid, tgt_hit;

    // Ripple carry through the four digits; roll marks the 59:59 -> 00:00 edge.
    always_comb begin
        c0   = (su == 4'd9);
        n_su = c0 ? 4'd0 : su + 4'd1;
        c1   = c0 && (st == 4'd5);
        n_st = c0 ? ((st == 4'd5) ? 4'd0 : st + 4'd1) : st;
        c2   = c1 && (mu == 4'd9);
        n_mu = c1 ? ((mu == 4'd9) ? 4'd0 : mu + 4'd1) : mu;
        roll = c2 && (mt == 4'd5);
        n_mt = c2 ? ((mt == 4'd5) ? 4'd0 : mt + 4'd1) : mt;
    end

    assign sec_tick  = (presc == PRESC_W'(TICKS_PER_SEC - 1));
    assign tgt_valid = (bus.target_min_tens <= 4'd5) && (bus.target_min_units <= 4'd9) &&
                       (bus.target_sec_tens <= 4'd5) && (bus.target_sec_units <= 4'd9);
    assign tgt_hit   = (tgt != 16'd0) && ({n_mt, n_mu, n_st, n_su} == tgt);

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            state    <= IDLE;
            presc    <= '0;
            {mt, mu, st, su} <= 16'd0;
            running  <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            if (reset)
                tgt <= 16'd0;
        end else begin
`ifdef TIMER_UP_WRAP_EN
            overflow <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.start && !bus.pause && tgt_valid) begin
                        tgt     <= {bus.target_min_tens, bus.target_min_units,
                                    bus.target_sec_tens, bus.target_sec_units};
                        presc   <= '0;
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (!sec_tick) begin
                        presc <= presc + 1'b1;
                    end else begin
                        presc <= '0;
                        if (roll) begin
`ifdef TIMER_UP_WRAP_EN
                            {mt, mu, st, su} <= 16'd0;
                            overflow         <= 1'b1;
`else
                            state    <= DONE;
                            running  <= 1'b0;
                            done     <= 1'b1;
                            overflow <= 1'b1;
`endif
                        end else begin
                            {mt, mu, st, su} <= {n_mt, n_mu, n_st, n_su};
                            if (tgt_hit) begin
                                state   <= DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (bus.start && !bus.pause) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.min_tens  = mt;
    assign bus.min_units = mu;
    assign bus.sec_tens  = st;
    assign bus.sec_units = su;
    assign bus.running   = running;
    assign bus.done      = done;
    assign bus.overflow  = overflow;
endmodule
